// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder front end.
package sha256_pkg;

  localparam logic [255:0] SHA256_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam int BLOCK_BYTES     = 64;
  localparam int LEN_FIELD_BYTES = 8;

  typedef enum logic [2:0] {
    S_FILL,
    S_LOAD,
    S_WAIT,
    S_EXTRA,
    S_DONE
  } padder_state_t;

endpackage

// File: rtl/sha256_pad_block.sv
// Combinational formatter: turns a partially filled buffer of k bytes into the
// padded final block and, when the length field does not fit, the extra block.
module sha256_pad_block
  import sha256_pkg::*;
(
  input  logic [511:0] data_buf,
  input  logic [6:0]   k,
  input  logic [63:0]  len_bits,
  output logic [511:0] first_blk,
  output logic [511:0] extra_blk,
  output logic         need_extra
);

  // Largest byte count that still leaves room for 0x80 plus the length field.
  localparam int MAX_SINGLE = BLOCK_BYTES - LEN_FIELD_BYTES - 1;

  always_comb begin
    first_blk = '0;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      if (7'(i) < k) begin
        first_blk[8*(63-i) +: 8] = data_buf[8*(63-i) +: 8];
      end else if (7'(i) == k) begin
        first_blk[8*(63-i) +: 8] = 8'h80;
      end
    end

    need_extra = (k > 7'(MAX_SINGLE));
    if (!need_extra) begin
      first_blk[63:0] = len_bits;
    end

    // A full 64-byte tail leaves no room for the terminator, so it opens the extra block.
    extra_blk = {(k == 7'(BLOCK_BYTES)) ? 8'h80 : 8'h00, 440'd0, len_bits};
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// Byte-stream to 512-bit block packer feeding hash_engine; applies SHA-256
// padding, chains hash_out between blocks and presents the final digest.
//
// state   | meaning
// S_FILL  | accepting bytes into the block buffer
// S_LOAD  | one-cycle load pulse to the engine
// S_WAIT  | engine busy; done ignored in the first cycle
// S_EXTRA | move the stored extra (length) block into the buffer
// S_DONE  | digest presented until digest_ready
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter logic [255:0] IV = SHA256_IV
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic         load,
  output logic [511:0] message_block,
  output logic [255:0] prev_hash,
  output logic         clear_hash,
  input  logic [255:0] hash_out,
  input  logic         local_hash_done,
  output logic [255:0] digest,
  output logic         digest_valid,
  input  logic         digest_ready
);

  padder_state_t state, state_nxt;

  logic [5:0]   byte_cnt;
  logic [60:0]  msg_len;
  logic [511:0] blk_q;
  logic [511:0] extra_q;
  logic         need_extra_q;
  logic         is_final;
  logic         wait_armed;
  logic [255:0] prev_q;

  logic         accept;
  logic         hash_seen;
  logic [511:0] buf_merged;
  logic [6:0]   k;
  logic [63:0]  len_bits;
  logic [511:0] pad_first;
  logic [511:0] pad_extra;
  logic         pad_need;

  assign accept    = (state == S_FILL) && in_valid;
  assign hash_seen = (state == S_WAIT) && wait_armed && local_hash_done;
  assign k         = {1'b0, byte_cnt} + 7'd1;
  assign len_bits  = {msg_len + 61'd1, 3'b000};

  // Byte n of the block sits at bits [511-8n -: 8]; ~byte_cnt equals 63-byte_cnt.
  always_comb begin
    buf_merged = blk_q;
    buf_merged[{~byte_cnt, 3'b000} +: 8] = in_data;
  end

  sha256_pad_block u_pad (
    .data_buf   (buf_merged),
    .k          (k),
    .len_bits   (len_bits),
    .first_blk  (pad_first),
    .extra_blk  (pad_extra),
    .need_extra (pad_need)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= S_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    in_ready     = 1'b0;
    load         = 1'b0;
    clear_hash   = 1'b0;
    digest_valid = 1'b0;
    case (state)
      S_FILL: begin
        in_ready = 1'b1;
        if (in_valid && (in_last || byte_cnt == 6'd63)) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        load      = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (wait_armed && local_hash_done) begin
          if (need_extra_q)  state_nxt = S_EXTRA;
          else if (is_final) state_nxt = S_DONE;
          else               state_nxt = S_FILL;
        end
      end
      S_EXTRA: begin
        state_nxt = S_LOAD;
      end
      S_DONE: begin
        digest_valid = 1'b1;
        if (digest_ready) begin
          clear_hash = 1'b1;
          state_nxt  = S_FILL;
        end
      end
      default: state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      byte_cnt     <= '0;
      msg_len      <= '0;
      blk_q        <= '0;
      extra_q      <= '0;
      need_extra_q <= 1'b0;
      is_final     <= 1'b0;
      wait_armed   <= 1'b0;
      prev_q       <= IV;
    end else begin
      // Low on entry to S_WAIT, high from its second cycle on.
      wait_armed <= (state == S_WAIT);

      if (accept) begin
        byte_cnt <= byte_cnt + 6'd1;
        msg_len  <= msg_len + 61'd1;
        if (in_last) begin
          blk_q        <= pad_first;
          extra_q      <= pad_extra;
          need_extra_q <= pad_need;
          is_final     <= !pad_need;
        end else begin
          blk_q <= buf_merged;
          if (byte_cnt == 6'd63) begin
            need_extra_q <= 1'b0;
            is_final     <= 1'b0;
          end
        end
      end

      if (hash_seen) begin
        prev_q <= hash_out;
        if (!need_extra_q && !is_final) begin
          byte_cnt <= '0;
        end
      end

      if (state == S_EXTRA) begin
        blk_q        <= extra_q;
        need_extra_q <= 1'b0;
        is_final     <= 1'b1;
      end

      if (state == S_DONE && digest_ready) begin
        prev_q   <= IV;
        msg_len  <= '0;
        byte_cnt <= '0;
        is_final <= 1'b0;
      end
    end
  end

  assign message_block = blk_q;
  assign prev_hash     = prev_q;
  assign digest        = prev_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: behavioural SHA-256 engine, reference padding
// model feeding block/digest scoreboards, and directed boundary scenarios.
module tb_sha256_msg_padder;
  import sha256_pkg::*;

  localparam logic [255:0] ABC_D =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D56 =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct packed {
    logic [511:0] blk;
    logic [255:0] prev;
  } exp_blk_t;

  logic         clk = 1'b0;
  logic         n_rst;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic         load;
  logic [511:0] message_block;
  logic [255:0] prev_hash;
  logic         clear_hash;
  logic [255:0] hash_out;
  logic         local_hash_done;
  logic [255:0] digest;
  logic         digest_valid;
  logic         digest_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_done_cyc = 0;
  int n_loads  = 0;
  int n_blk_pushed = 0;
  logic load_prev = 1'b0;
  logic stray_en  = 1'b0;

  logic [7:0]   msg_q [$];
  exp_blk_t     sb_blk [$];
  logic [255:0] sb_dig [$];

  logic [511:0] eng_blk;
  logic [255:0] eng_prev;
  int           eng_cnt;

  sha256_msg_padder #(.IV(SHA256_IV)) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_last         (in_last),
    .in_ready        (in_ready),
    .load            (load),
    .message_block   (message_block),
    .prev_hash       (prev_hash),
    .clear_hash      (clear_hash),
    .hash_out        (hash_out),
    .local_hash_done (local_hash_done),
    .digest          (digest),
    .digest_valid    (digest_valid),
    .digest_ready    (digest_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  // Behavioural engine: busy 65 cycles after load; optional bogus done in the
  // first cycle after load, which the padder must ignore.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      eng_cnt         <= 0;
      local_hash_done <= 1'b0;
      hash_out        <= '0;
      eng_blk         <= '0;
      eng_prev        <= '0;
    end else begin
      local_hash_done <= 1'b0;
      if (load) begin
        eng_blk  <= message_block;
        eng_prev <= prev_hash;
        eng_cnt  <= 65;
        if (stray_en) begin
          local_hash_done <= 1'b1;
          hash_out        <= ~prev_hash;
        end
      end else if (eng_cnt == 1) begin
        local_hash_done <= 1'b1;
        hash_out        <= compress(eng_prev, eng_blk);
        eng_cnt         <= 0;
      end else if (eng_cnt > 1) begin
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (n_rst && load) begin
      check_eq("load_one_cycle", load_prev, 1'b0);
      check_eq("load_has_exp", sb_blk.size() != 0, 1'b1);
      if (sb_blk.size() != 0) begin
        check_eq("block", message_block, sb_blk[0].blk);
        check_eq("prev_hash", prev_hash, sb_blk[0].prev);
        void'(sb_blk.pop_front());
      end
      n_loads <= n_loads + 1;
    end
    load_prev <= n_rst && load;
    if (n_rst && local_hash_done) begin
      last_done_cyc <= cyc;
      check_eq("blk_stable", message_block, eng_blk);
      check_eq("prev_stable", prev_hash, eng_prev);
    end
  end

  task automatic set_str(input string s);
    msg_q.delete();
    for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
  endtask

  task automatic set_rand(input int n, input logic zeros);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(zeros ? 8'h00 : 8'($urandom_range(0, 255)));
  endtask

  // Reference padding of msg_q; pushes expected blocks with chaining values and the digest.
  task automatic ref_push(input logic use_const, input logic [255:0] cd);
    logic [7:0]   p [$];
    logic [63:0]  bits;
    logic [511:0] blk;
    logic [255:0] h;
    exp_blk_t     e;
    p = msg_q;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(msg_q.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    h = SHA256_IV;
    for (int bi = 0; bi < p.size() / 64; bi++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[bi*64 + j];
      e.blk  = blk;
      e.prev = h;
      sb_blk.push_back(e);
      n_blk_pushed++;
      h = compress(h, blk);
    end
    sb_dig.push_back(use_const ? cd : h);
  endtask

  task automatic send_msg(input logic chk_bp);
    int waits;
    for (int i = 0; i < msg_q.size(); i++) begin
      @(negedge clk);
      in_data  = msg_q[i];
      in_valid = 1'b1;
      in_last  = (i == msg_q.size() - 1);
      waits = 0;
      if (chk_bp && i == 64) check_eq("bp_ready_low", in_ready, 1'b0);
      while (!in_ready && waits < 2000) begin
        @(negedge clk);
        waits++;
      end
      if (waits >= 2000) check_eq("in_ready_timeout", in_ready, 1'b1);
      if (chk_bp && i == 64) check_eq("bp_wait_ge65", waits >= 65, 1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic recv_digest(input int hold);
    int b;
    logic [255:0] exp;
    b = 0;
    while (!digest_valid && b < 3000) begin
      @(negedge clk);
      b++;
    end
    check_eq("digest_valid", digest_valid, 1'b1);
    check_eq("digest_latency", cyc - last_done_cyc, 1);
    exp = (sb_dig.size() != 0) ? sb_dig.pop_front() : '0;
    check_eq("digest", digest, exp);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check_eq("digest_hold_valid", digest_valid, 1'b1);
      check_eq("digest_hold_value", digest, exp);
    end
    digest_ready = 1'b1;
    #1;
    check_eq("clear_hash_pulse", clear_hash, 1'b1);
    @(negedge clk);
    digest_ready = 1'b0;
    check_eq("clear_hash_once", clear_hash, 1'b0);
    check_eq("in_ready_after_acc", in_ready, 1'b1);
    check_eq("digest_valid_drop", digest_valid, 1'b0);
    check_eq("digest_iv_after_acc", digest, SHA256_IV);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_in_ready"}, in_ready, 1'b1);
    check_eq({tag, "_load"}, load, 1'b0);
    check_eq({tag, "_clear_hash"}, clear_hash, 1'b0);
    check_eq({tag, "_digest_valid"}, digest_valid, 1'b0);
    check_eq({tag, "_message_block"}, message_block, '0);
    check_eq({tag, "_prev_hash"}, prev_hash, SHA256_IV);
    check_eq({tag, "_digest"}, digest, SHA256_IV);
  endtask

  initial begin
    int b;
    n_rst = 1'b0;
    in_data = '0;
    in_valid = 1'b0;
    in_last = 1'b0;
    digest_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    n_rst = 1'b1;
    @(negedge clk);

    set_str("abc"); ref_push(1'b1, ABC_D); send_msg(1'b0); recv_digest(10);
    set_str("abc"); ref_push(1'b1, ABC_D); send_msg(1'b0); recv_digest(0);
    set_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    ref_push(1'b1, D56); send_msg(1'b0); recv_digest(2);
    set_rand(64, 1'b1); ref_push(1'b0, '0); send_msg(1'b0); recv_digest(0);
    stray_en = 1'b1;
    set_rand(55, 1'b0); ref_push(1'b0, '0); send_msg(1'b0); recv_digest(0);
    stray_en = 1'b0;
    set_rand(63, 1'b0); ref_push(1'b0, '0); send_msg(1'b0); recv_digest(0);
    set_rand(70, 1'b0); ref_push(1'b0, '0); send_msg(1'b1); recv_digest(0);

    // Reset while the engine is busy with the block.
    set_str("abc"); ref_push(1'b1, ABC_D); send_msg(1'b0);
    b = 0;
    while (!load && b < 100) begin
      @(negedge clk);
      b++;
    end
    repeat (5) @(negedge clk);
    n_rst = 1'b0;
    #1;
    check_reset("rst_mid");
    sb_dig.delete();
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    set_str("abc"); ref_push(1'b1, ABC_D); send_msg(1'b0); recv_digest(0);

    repeat (3) @(negedge clk);
    check_eq("load_count", n_loads, n_blk_pushed);
    check_eq("blk_sb_empty", sb_blk.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
